txr_channel_arbiter: RTL and testbench

TXR_CHANNEL_ARBITER -- requirements
Module: txr_channel_arbiter

---
 rtl/txr_channel_arbiter.sv | 129 ++++++++++++
 tb/tb_txr_channel_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txr_channel_arbiter.sv
// Round-robin arbiter multiplexing per-channel TXR meta/data streams onto one engine port.
// A grant is held from meta acceptance through the final payload beat.
module txr_channel_arbiter #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_NUM_CHNL       = 4,
  parameter int C_META_WIDTH     = 128,
  localparam int C_OFF_WIDTH     = (C_PCI_DATA_WIDTH / 32 > 1) ? $clog2(C_PCI_DATA_WIDTH / 32) : 1,
  localparam int C_IDX_WIDTH     = $clog2(C_NUM_CHNL)
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,

  input  logic [C_NUM_CHNL-1:0]                 CHNL_META_VALID,
  input  logic [C_NUM_CHNL*C_META_WIDTH-1:0]    CHNL_META,
  input  logic [C_NUM_CHNL-1:0]                 CHNL_META_NOPAYLOAD,
  output logic [C_NUM_CHNL-1:0]                 CHNL_META_READY,

  input  logic [C_NUM_CHNL-1:0]                 CHNL_DATA_VALID,
  input  logic [C_NUM_CHNL-1:0]                 CHNL_DATA_START_FLAG,
  input  logic [C_NUM_CHNL-1:0]                 CHNL_DATA_END_FLAG,
  input  logic [C_NUM_CHNL*C_PCI_DATA_WIDTH-1:0] CHNL_DATA,
  input  logic [C_NUM_CHNL*C_OFF_WIDTH-1:0]     CHNL_DATA_START_OFFSET,
  input  logic [C_NUM_CHNL*C_OFF_WIDTH-1:0]     CHNL_DATA_END_OFFSET,
  output logic [C_NUM_CHNL-1:0]                 CHNL_DATA_READY,

  output logic                                  TXR_META_VALID,
  output logic [C_META_WIDTH-1:0]               TXR_META,
  input  logic                                  TXR_META_READY,

  output logic                                  TXR_DATA_VALID,
  output logic [C_PCI_DATA_WIDTH-1:0]           TXR_DATA,
  output logic                                  TXR_DATA_START_FLAG,
  output logic [C_OFF_WIDTH-1:0]                TXR_DATA_START_OFFSET,
  output logic                                  TXR_DATA_END_FLAG,
  output logic [C_OFF_WIDTH-1:0]                TXR_DATA_END_OFFSET,
  input  logic                                  TXR_DATA_READY,

  output logic [C_NUM_CHNL-1:0]                 GRANT,
  output logic                                  BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_META, ST_DATA} state_t;

  state_t                 state;
  logic [C_IDX_WIDTH-1:0] grant_idx;
  logic [C_IDX_WIDTH-1:0] last_grant;
  logic [C_IDX_WIDTH-1:0] next_idx;
  logic                   any_req;

  // Scan downward so the last hit is the nearest requester above last_grant.
  always_comb begin
    int cand;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_idx = last_grant;
    any_req  = |CHNL_META_VALID;
    cand     = 0;
    for (int i = C_NUM_CHNL; i >= 1; i--) begin
      cand = int'(last_grant) + i;
      if (cand >= C_NUM_CHNL) cand = cand - C_NUM_CHNL;
      if (CHNL_META_VALID[cand]) next_idx = C_IDX_WIDTH'(cand);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= C_IDX_WIDTH'(C_NUM_CHNL - 1);
      GRANT      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_idx  <= next_idx;
            last_grant <= next_idx;
            GRANT      <= C_NUM_CHNL'(1) << next_idx;
            state      <= ST_META;
          end
        end
        ST_META: begin
          if (CHNL_META_VALID[grant_idx] && TXR_META_READY) begin
            if (CHNL_META_NOPAYLOAD[grant_idx]) begin
              state <= ST_IDLE;
              GRANT <= '0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (CHNL_DATA_VALID[grant_idx] && TXR_DATA_READY && CHNL_DATA_END_FLAG[grant_idx]) begin
            state <= ST_IDLE;
            GRANT <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          GRANT <= '0;
        end
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);

  // Payload fields follow the granted channel; only valid/ready are gated by state.
  always_comb begin
    TXR_META              = CHNL_META[int'(grant_idx) * C_META_WIDTH +: C_META_WIDTH];
    TXR_DATA              = CHNL_DATA[int'(grant_idx) * C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];
    TXR_DATA_START_FLAG   = CHNL_DATA_START_FLAG[grant_idx];
    TXR_DATA_END_FLAG     = CHNL_DATA_END_FLAG[grant_idx];
    TXR_DATA_START_OFFSET = CHNL_DATA_START_OFFSET[int'(grant_idx) * C_OFF_WIDTH +: C_OFF_WIDTH];
    TXR_DATA_END_OFFSET   = CHNL_DATA_END_OFFSET[int'(grant_idx) * C_OFF_WIDTH +: C_OFF_WIDTH];
    TXR_META_VALID        = 1'b0;
    TXR_DATA_VALID        = 1'b0;
    CHNL_META_READY       = '0;
    CHNL_DATA_READY       = '0;
    if (state == ST_META) begin
      TXR_META_VALID             = CHNL_META_VALID[grant_idx];
      CHNL_META_READY[grant_idx] = TXR_META_READY;
    end
    if (state == ST_DATA) begin
      TXR_DATA_VALID             = CHNL_DATA_VALID[grant_idx];
      CHNL_DATA_READY[grant_idx] = TXR_DATA_READY;
    end
  end

endmodule

// File: tb/tb_txr_channel_arbiter.sv
// Directed bench for txr_channel_arbiter: rotation, payload forwarding, priority, abort and stall.
module tb_txr_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int MW = 128;
  localparam int OW = 2;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      chnl_meta_valid;
  logic [N*MW-1:0]   chnl_meta;
  logic [N-1:0]      chnl_meta_nopayload;
  logic [N-1:0]      chnl_meta_ready;
  logic [N-1:0]      chnl_data_valid;
  logic [N-1:0]      chnl_data_start_flag;
  logic [N-1:0]      chnl_data_end_flag;
  logic [N*DW-1:0]   chnl_data;
  logic [N*OW-1:0]   chnl_data_start_offset;
  logic [N*OW-1:0]   chnl_data_end_offset;
  logic [N-1:0]      chnl_data_ready;
  logic              txr_meta_valid;
  logic [MW-1:0]     txr_meta;
  logic              txr_meta_ready;
  logic              txr_data_valid;
  logic [DW-1:0]     txr_data;
  logic              txr_data_start_flag;
  logic [OW-1:0]     txr_data_start_offset;
  logic              txr_data_end_flag;
  logic [OW-1:0]     txr_data_end_offset;
  logic              txr_data_ready;
  logic [N-1:0]      grant;
  logic              busy;

  int checks = 0;
  int errors = 0;

  txr_channel_arbiter #(
    .C_PCI_DATA_WIDTH(DW),
    .C_NUM_CHNL(N),
    .C_META_WIDTH(MW)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .CHNL_META_VALID(chnl_meta_valid),
    .CHNL_META(chnl_meta),
    .CHNL_META_NOPAYLOAD(chnl_meta_nopayload),
    .CHNL_META_READY(chnl_meta_ready),
    .CHNL_DATA_VALID(chnl_data_valid),
    .CHNL_DATA_START_FLAG(chnl_data_start_flag),
    .CHNL_DATA_END_FLAG(chnl_data_end_flag),
    .CHNL_DATA(chnl_data),
    .CHNL_DATA_START_OFFSET(chnl_data_start_offset),
    .CHNL_DATA_END_OFFSET(chnl_data_end_offset),
    .CHNL_DATA_READY(chnl_data_ready),
    .TXR_META_VALID(txr_meta_valid),
    .TXR_META(txr_meta),
    .TXR_META_READY(txr_meta_ready),
    .TXR_DATA_VALID(txr_data_valid),
    .TXR_DATA(txr_data),
    .TXR_DATA_START_FLAG(txr_data_start_flag),
    .TXR_DATA_START_OFFSET(txr_data_start_offset),
    .TXR_DATA_END_FLAG(txr_data_end_flag),
    .TXR_DATA_END_OFFSET(txr_data_end_offset),
    .TXR_DATA_READY(txr_data_ready),
    .GRANT(grant),
    .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] meta_word(input int c);
    return {32'hA5A5_0000 | 32'(c), 32'(c) * 32'h0101, 64'hDEAD_BEEF_0000_0000 | 64'(c)};
  endfunction

  function automatic logic [DW-1:0] beat_word(input int c, input int b);
    return {32'(c), 32'(b), 64'hFEED_0000_0000_0000 | 64'(c * 16 + b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    chnl_meta_valid        = '0;
    chnl_meta_nopayload    = '0;
    chnl_data_valid        = '0;
    chnl_data_start_flag   = '0;
    chnl_data_end_flag     = '0;
    chnl_data              = '0;
    chnl_data_start_offset = '0;
    chnl_data_end_offset   = '0;
    txr_meta_ready         = 1'b0;
    txr_data_ready         = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_data(input int c, input logic v, input logic s, input logic e,
                          input logic [DW-1:0] d, input logic [OW-1:0] so, input logic [OW-1:0] eo);
    chnl_data_valid[c]                 = v;
    chnl_data_start_flag[c]            = s;
    chnl_data_end_flag[c]              = e;
    chnl_data[c*DW +: DW]              = d;
    chnl_data_start_offset[c*OW +: OW] = so;
    chnl_data_end_offset[c*OW +: OW]   = eo;
  endtask

  logic [N-1:0] rr_exp [9];
  int           rr_idx [9];
  logic         rdy_pat [5];

  initial begin
    int bi;
    int fwd;
    rr_exp  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    rr_idx  = '{0, 0, 1, 0, 2, 0, 3, 0, 0};
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    clear_inputs();
    for (int c = 0; c < N; c++) chnl_meta[c*MW +: MW] = meta_word(c);
    step();
    step();

    // Reset state, including with requests pending while reset is held.
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    chnl_meta_valid     = 4'b1111;
    chnl_meta_nopayload = 4'b1111;
    txr_meta_ready      = 1'b1;
    chnl_data_valid     = 4'b1111;
    txr_data_ready      = 1'b1;
    #1;
    check("rst_meta_valid", txr_meta_valid, 1'b0);
    check("rst_meta_ready", chnl_meta_ready, 4'b0000);
    check("rst_data_valid", txr_data_valid, 1'b0);
    check("rst_data_ready", chnl_data_ready, 4'b0000);
    step();
    check("rst_grant_held", grant, 4'b0000);

    // Round robin with all channels requesting, no payload.
    chnl_data_valid = '0;
    txr_data_ready  = 1'b0;
    rst_n           = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      check("rr_grant", grant, rr_exp[k]);
      check("rr_meta_ready", chnl_meta_ready, rr_exp[k]);
      check("rr_busy", busy, rr_exp[k] != 4'b0000);
      if (rr_exp[k] != 4'b0000) check("rr_meta", txr_meta, meta_word(rr_idx[k]));
    end
    do_reset();

    // Channel 2 three-beat packet under a toggling engine ready.
    chnl_meta_valid = 4'b0100;
    txr_meta_ready  = 1'b1;
    set_data(1, 1'b1, 1'b1, 1'b1, beat_word(1, 9), 2'd2, 2'd2);
    set_data(3, 1'b1, 1'b1, 1'b0, beat_word(3, 9), 2'd0, 2'd0);
    set_data(2, 1'b1, 1'b1, 1'b0, beat_word(2, 1), 2'd1, 2'd3);
    step();
    check("p3_grant_meta", grant, 4'b0100);
    check("p3_meta_valid", txr_meta_valid, 1'b1);
    check("p3_meta", txr_meta, meta_word(2));
    check("p3_no_data_in_meta", txr_data_valid, 1'b0);
    step();
    chnl_meta_valid = '0;
    bi  = 1;
    fwd = 0;
    for (int k = 0; k < 5; k++) begin
      txr_data_ready = rdy_pat[k];
      set_data(2, 1'b1, bi == 1, bi == 3, beat_word(2, bi), 2'd1, 2'd3);
      #1;
      check("p3_data", txr_data, beat_word(2, bi));
      check("p3_data_valid", txr_data_valid, 1'b1);
      check("p3_end_flag", txr_data_end_flag, bi == 3);
      check("p3_start_flag", txr_data_start_flag, bi == 1);
      check("p3_chnl_ready", chnl_data_ready, rdy_pat[k] ? 4'b0100 : 4'b0000);
      check("p3_grant", grant, 4'b0100);
      if (k == 0) begin
        check("p3_start_off", txr_data_start_offset, 2'd1);
        check("p3_end_off", txr_data_end_offset, 2'd3);
      end
      if (txr_data_valid && txr_data_ready) fwd++;
      if (rdy_pat[k]) bi++;
      step();
    end
    check("p3_beats_fwd", fwd, 3);
    check("p3_idle_busy", busy, 1'b0);
    check("p3_idle_grant", grant, 4'b0000);
    check("p3_idle_data_valid", txr_data_valid, 1'b0);
    do_reset();

    // Channel 1 busy in DATA while 0 and 3 request: 3 wins next, then 0.
    chnl_meta_valid = 4'b0010;
    txr_meta_ready  = 1'b1;
    step();
    check("pri_grant1", grant, 4'b0010);
    step();
    chnl_meta_valid     = 4'b1001;
    chnl_meta_nopayload = 4'b1001;
    set_data(1, 1'b1, 1'b1, 1'b1, beat_word(1, 0), 2'd0, 2'd0);
    txr_data_ready = 1'b0;
    #1;
    check("pri_hold_grant", grant, 4'b0010);
    check("pri_no_meta_ready", chnl_meta_ready, 4'b0000);
    check("pri_no_meta_valid", txr_meta_valid, 1'b0);
    step();
    check("pri_hold_grant2", grant, 4'b0010);
    txr_data_ready = 1'b1;
    step();
    check("pri_idle", busy, 1'b0);
    set_data(1, 1'b0, 1'b0, 1'b0, '0, 2'd0, 2'd0);
    step();
    check("pri_grant3", grant, 4'b1000);
    check("pri_meta3", txr_meta, meta_word(3));
    step();
    step();
    check("pri_grant0", grant, 4'b0001);
    do_reset();

    // Single-beat packet on channel 0.
    chnl_meta_valid = 4'b0001;
    txr_meta_ready  = 1'b1;
    step();
    step();
    chnl_meta_valid = '0;
    set_data(0, 1'b1, 1'b1, 1'b1, beat_word(0, 5), 2'd0, 2'd3);
    txr_data_ready = 1'b1;
    #1;
    check("sb_valid", txr_data_valid, 1'b1);
    check("sb_flags", {txr_data_start_flag, txr_data_end_flag}, 2'b11);
    check("sb_data", txr_data, beat_word(0, 5));
    check("sb_busy", busy, 1'b1);
    step();
    check("sb_after_busy", busy, 1'b0);
    check("sb_after_valid", txr_data_valid, 1'b0);
    check("sb_after_ready", chnl_data_ready, 4'b0000);
    do_reset();

    // Asynchronous abort after beat 1 of 4.
    chnl_meta_valid = 4'b0001;
    txr_meta_ready  = 1'b1;
    step();
    step();
    chnl_meta_valid = '0;
    txr_data_ready  = 1'b1;
    set_data(0, 1'b1, 1'b1, 1'b0, beat_word(0, 1), 2'd0, 2'd0);
    #1;
    check("ab_beat1", txr_data, beat_word(0, 1));
    step();
    set_data(0, 1'b1, 1'b0, 1'b0, beat_word(0, 2), 2'd0, 2'd0);
    #1;
    check("ab_pre_valid", txr_data_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ab_valid", txr_data_valid, 1'b0);
    check("ab_ready", chnl_data_ready, 4'b0000);
    check("ab_grant", grant, 4'b0000);
    check("ab_busy", busy, 1'b0);
    step();
    clear_inputs();
    chnl_meta_valid     = 4'b0011;
    chnl_meta_nopayload = 4'b0011;
    txr_meta_ready      = 1'b1;
    rst_n               = 1'b1;
    step();
    check("ab_restart_grant", grant, 4'b0001);
    do_reset();

    // Engine stalls meta for 10 cycles.
    chnl_meta_valid = 4'b1111;
    txr_meta_ready  = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      check("st_meta_valid", txr_meta_valid, 1'b1);
      check("st_grant", grant, 4'b0001);
      check("st_ready", chnl_meta_ready, 4'b0000);
      step();
    end
    txr_meta_ready = 1'b1;
    #1;
    check("st_ready_go", chnl_meta_ready, 4'b0001);
    step();
    check("st_data_busy", busy, 1'b1);
    check("st_data_no_meta", txr_meta_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
